// File: rtl/debounce_pkg.sv
// debounce_pkg: shared FSM state encoding and sizing helper for the debounce bank
package debounce_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RISE_WAIT = 2'd1,
    HELD      = 2'd2,
    FALL_WAIT = 2'd3
  } state_t;
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: synchroniser, stable-interval filter and auto-repeat for one input
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int INTERVAL      = 500000,
  parameter int SYNC_STAGES   = 2,
  parameter int INVERT        = 0,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_noisy,
  output logic o_debounced,
  output logic o_pressed,
  output logic o_released,
  output logic o_repeat
);
  localparam int CW = $clog2(max3(INTERVAL, REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [CW-1:0] LIM_INT = CW'(INTERVAL - 1);
  localparam logic [CW-1:0] LIM_DLY = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] LIM_PER = CW'(REPEAT_PERIOD - 1);
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0] r_cnt;
  state_t r_state, w_next;
  logic r_flag, w_flag, w_clr, w_press, w_rel, w_rep, w_s;
  assign w_s = r_sync[SYNC_STAGES-1] ^ 1'(INVERT);
  // reset loads the inactive raw level so no phantom edge appears on release
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_sync <= {SYNC_STAGES{1'(INVERT)}};
    else r_sync <= {r_sync[SYNC_STAGES-2:0], i_noisy};
  always_comb begin
    w_next  = r_state;
    w_flag  = r_flag;
    w_clr   = 1'b0;
    w_press = 1'b0;
    w_rel   = 1'b0;
    w_rep   = 1'b0;
    case (r_state)
      IDLE:
        if (w_s) begin
          w_next = RISE_WAIT;
          w_clr  = 1'b1;
        end
      RISE_WAIT:
        if (!w_s) begin
          w_next = IDLE;
          w_clr  = 1'b1;
        end else if (r_cnt == LIM_INT) begin
          w_next  = HELD;
          w_clr   = 1'b1;
          w_flag  = 1'b0;
          w_press = 1'b1;
        end
      HELD:
        if (!w_s) begin
          w_next = FALL_WAIT;
          w_clr  = 1'b1;
        end else if (REPEAT_EN != 0 && r_cnt == (r_flag ? LIM_PER : LIM_DLY)) begin
          w_rep  = 1'b1;
          w_clr  = 1'b1;
          w_flag = 1'b1;
        end
      FALL_WAIT:
        if (w_s) begin
          w_next = HELD;
          w_clr  = 1'b1;
          w_flag = 1'b0;
        end else if (r_cnt == LIM_INT) begin
          w_next = IDLE;
          w_clr  = 1'b1;
          w_flag = 1'b0;
          w_rel  = 1'b1;
        end
      default: begin
        w_next = IDLE;
        w_clr  = 1'b1;
        w_flag = 1'b0;
      end
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_flag      <= 1'b0;
      o_debounced <= 1'b0;
      o_pressed   <= 1'b0;
      o_released  <= 1'b0;
      o_repeat    <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_clr ? '0 : r_cnt + 1'b1;
      r_flag      <= w_flag;
      o_debounced <= (w_next == HELD) || (w_next == FALL_WAIT);
      o_pressed   <= w_press;
      o_released  <= w_rel;
      o_repeat    <= w_rep;
    end
endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: CHANNELS independent debounce channels for the joypad button set
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int CHANNELS      = 8,
  parameter int INTERVAL      = 500000,
  parameter int SYNC_STAGES   = 2,
  parameter int INVERT        = 0,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic [CHANNELS-1:0] i_noisy,
  output logic [CHANNELS-1:0] o_debounced,
  output logic [CHANNELS-1:0] o_pressed,
  output logic [CHANNELS-1:0] o_released,
  output logic [CHANNELS-1:0] o_repeat
);
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    debounce_channel #(
      .INTERVAL     (INTERVAL),
      .SYNC_STAGES  (SYNC_STAGES),
      .INVERT       (INVERT),
      .REPEAT_EN    (REPEAT_EN),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .i_clk      (i_clk),
      .i_rst_n    (i_reset_n),
      .i_noisy    (i_noisy[c]),
      .o_debounced(o_debounced[c]),
      .o_pressed  (o_pressed[c]),
      .o_released (o_released[c]),
      .o_repeat   (o_repeat[c])
    );
  end
endmodule

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
- Multi-channel successor to the single-input debouncer, sized for the full joypad button set.
- Each channel synchronises its raw input and filters it with a stable-interval state machine.
- Each channel emits a level output, single-cycle press/release pulses and an optional auto-repeat pulse.
- Sits between the board button pins and the joypad register / UI logic; one instance serves every button.

Parameters:
- CHANNELS, 8: number of independent inputs.
- INTERVAL, 500000: consecutive stable clk cycles (post-sync) required to accept a level change; must be >= 1.
- SYNC_STAGES, 2: synchroniser flops per channel; must be >= 2.
- INVERT, 0: 1 = raw inputs are active-low; inverted immediately after synchronisation.
- REPEAT_EN, 0: 1 = enable the auto-repeat output.
- REPEAT_DELAY, 25000000: cycles from the press pulse to the first repeat pulse.
- REPEAT_PERIOD, 5000000: cycles between subsequent repeat pulses.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- noisy  input  CHANNELS  raw asynchronous inputs.
- debounced  output  CHANNELS  filtered active-high levels.
- pressed  output  CHANNELS  1-cycle pulse on each accepted 0->1 change.
- released  output  CHANNELS  1-cycle pulse on each accepted 1->0 change.
- repeat  output  CHANNELS  1-cycle auto-repeat pulse while a channel is held; constant 0 when REPEAT_EN=0.

Behaviour:
- Reset (reset=0): asynchronous and immediate.
  - All outputs 0; every FSM to IDLE; counters 0.
  - Synchroniser flops load the inactive raw level: INVERT, giving 0 after inversion.
- Synchroniser: SYNC_STAGES flops per channel; s = last stage XOR INVERT. Channels are fully independent; no shared state.
- Counter: one per channel, width $clog2(max(INTERVAL, REPEAT_DELAY, REPEAT_PERIOD)+1). It is cleared on every state entry and increments each cycle otherwise.
- FSM states, per channel:
  - IDLE: debounced=0. s=1 -> RISE_WAIT, counter cleared.
  - RISE_WAIT: debounced=0.
    - s=0 -> IDLE (glitch rejected, no pulse).
    - s=1 and counter == INTERVAL-1 -> HELD, with pressed=1 for exactly the cycle debounced first reads 1.
  - HELD: debounced=1.
    - s=0 -> FALL_WAIT, counter cleared.
    - Repeat (REPEAT_EN=1 only): repeat=1 for one cycle when counter reaches REPEAT_DELAY-1 while first-repeat flag is clear. Then set the flag and clear the counter.
    - With the flag set, repeat=1 each time counter reaches REPEAT_PERIOD-1, then clear the counter.
  - FALL_WAIT: debounced=1; repeat suppressed.
    - s=1 -> HELD; counter and first-repeat flag cleared, so repeat timing restarts from REPEAT_DELAY; no pulses.
    - s=0 and counter == INTERVAL-1 -> IDLE, with released=1 for exactly the cycle debounced first reads 0.
- Latency: a clean raw edge appears on debounced, pressed or released exactly SYNC_STAGES+INTERVAL cycles later.
- Latency: the first repeat occurs REPEAT_DELAY cycles after pressed; later repeats follow every REPEAT_PERIOD cycles.
- Outputs are registered, not decoded combinationally from next state.
- Mutual exclusion: pressed, released and repeat are never high together on one channel.
- INTERVAL=1: a single stable post-sync cycle is accepted.
- Reset mid-operation (any state): all outputs drop immediately. After reset release, a raw input still held active is re-detected as a fresh press after the full latency.
- Illegal/unreachable state encoding: return to IDLE.

Decomposition:
- debounce_pkg holds the state enum (IDLE, RISE_WAIT, HELD, FALL_WAIT), 2-bit logic.
- debounce_pkg also holds a max3 constant function used for the counter width.
- Sub-module debounce_channel: one synchroniser, FSM, counter and repeat flag.
- debounce_bank instantiates CHANNELS copies of debounce_channel in a generate loop and concatenates their outputs.

Test Plan (CHANNELS=4, INTERVAL=4, SYNC_STAGES=2, REPEAT_DELAY=10, REPEAT_PERIOD=5, INVERT=0, REPEAT_EN=1 unless noted):
1. Clean press: noisy[0] 0->1 at cycle T and held -> debounced[0]=1 from T+6; pressed[0]=1 only at T+6; channels 1-3 stay 0.
2. Glitch reject: noisy[0] high for 3 cycles, then low -> debounced, pressed and released stay 0 throughout.
3. Release bounce: while held, noisy[0] low for 2 cycles then high -> no released and debounced stays 1. A clean drop at cycle U then gives released[0] at U+6 and debounced=0 from U+6.
4. Auto-repeat: hold noisy[1] -> pressed at P, repeat at P+10, P+15 and P+20, none in between. With REPEAT_EN=0, the same stimulus gives repeat never high.
5. Parallel and inverted: INVERT=1, noisy[3:2] driven 1->0 in the same cycle -> both channels show identical pressed/debounced timing (T+6). Other channels are unaffected.
6. Reset mid-hold: assert reset while debounced[0]=1 -> all outputs 0 in the same cycle. Release reset with noisy[0] still 1 -> pressed[0] reappears exactly 6 cycles after the release.
